// File: rtl/bus_sequencer_if.sv
// bus_sequencer_if: requester handshake and peripheral strobe bundle for bus_sequencer.
// The tristate sysbus is a separate inout port on the sequencer, so bus resolution
// happens on a plain net at the level that also holds the peripherals.
interface bus_sequencer_if #(
  parameter int WORD_W = 10,
  parameter int OP_W   = 3
);
  localparam int AW = WORD_W - OP_W;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [AW-1:0]     addr0;
  logic [AW-1:0]     addr1;
  logic [WORD_W-1:0] wdata0;
  logic [WORD_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [WORD_W-1:0] rdata;
  logic              busy;
  logic              load_MAR;
  logic              load_MDR;
  logic              CS;
  logic              R_NW;

  // Requester / environment side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy, load_MAR, load_MDR, CS, R_NW
  );

  // Sequencer side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy, load_MAR, load_MDR, CS, R_NW
  );
endinterface

// File: rtl/bus_sequencer.sv
// bus_sequencer: two-requester sysbus controller. Each access runs
// ADDR -> (WDATA -> WSTROBE | RSTROBE -> RCAP) -> ACK, followed by IDLE.
// Optional feature macro: BUS_SEQ_ROUND_ROBIN_EN (round-robin tie break);
// without it requester 0 wins every tie.
module bus_sequencer #(
  parameter int WORD_W = 10,
  parameter int OP_W   = 3
) (
  input  logic             clock,
  input  logic             n_reset,
  bus_sequencer_if.slave   bus,
  inout  wire [WORD_W-1:0] sysbus
);
  localparam int AW = WORD_W - OP_W;

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WSTROBE, RSTROBE, RCAP, ACK
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_id;
  logic              req_we;
  logic [AW-1:0]     req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [WORD_W-1:0] rdata_q;
  logic              last_grant;
  logic              mask_valid;
  logic              elig0;
  logic              elig1;
  logic              tie_pick;
  logic              grant;
  logic              grant_sel;
  logic              drive_en;
  logic [WORD_W-1:0] drive_val;
  logic              mar_strobe;
  logic              mdr_strobe;
  logic              cs_strobe;
  logic              rnw;
  logic              ack0_o;
  logic              ack1_o;

  // The requester just acknowledged is ignored for the single IDLE cycle after ACK
  always_comb begin
    elig0 = bus.req0 && !(mask_valid && !grant_id);
    elig1 = bus.req1 && !(mask_valid && grant_id);
  end

  // Tie break between two eligible requesters
  always_comb begin
`ifdef BUS_SEQ_ROUND_ROBIN_EN
    tie_pick = ~last_grant;
`else
    // last_grant is still tracked, but fixed priority always favours requester 0
    tie_pick = last_grant & 1'b0;
`endif
  end

  // Next-state and strobe decode; strobes depend on the state register only
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    drive_en   = 1'b0;
    drive_val  = '0;
    mar_strobe = 1'b0;
    mdr_strobe = 1'b0;
    cs_strobe  = 1'b0;
    rnw        = 1'b1;
    ack0_o     = 1'b0;
    ack1_o     = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          grant     = 1'b1;
          grant_sel = (elig0 && elig1) ? tie_pick : elig1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        drive_en   = 1'b1;
        drive_val  = {{OP_W{1'b0}}, req_addr};
        mar_strobe = 1'b1;
        state_nxt  = req_we ? WDATA : RSTROBE;
      end
      WDATA: begin
        drive_en   = 1'b1;
        drive_val  = req_wdata;
        mdr_strobe = 1'b1;
        state_nxt  = WSTROBE;
      end
      WSTROBE: begin
        cs_strobe = 1'b1;
        rnw       = 1'b0;
        state_nxt = ACK;
      end
      RSTROBE: begin
        cs_strobe = 1'b1;
        state_nxt = RCAP;
      end
      RCAP: begin
        cs_strobe = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        ack0_o    = ~grant_id;
        ack1_o    = grant_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture the granted request so the inputs are free until the next IDLE
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      grant_id  <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (grant) begin
      grant_id  <= grant_sel;
      req_we    <= grant_sel ? bus.we1    : bus.we0;
      req_addr  <= grant_sel ? bus.addr1  : bus.addr0;
      req_wdata <= grant_sel ? bus.wdata1 : bus.wdata0;
    end
  end

  // Arbitration history and the one-cycle hold-off flag
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      last_grant <= 1'b1;
      mask_valid <= 1'b0;
    end else begin
      mask_valid <= (state == ACK);
      if (grant) last_grant <= grant_sel;
    end
  end

  // Read data is taken from the bus at the edge closing RCAP, stored as seen
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)           rdata_q <= '0;
    else if (state == RCAP) rdata_q <= sysbus;
  end

  assign sysbus       = drive_en ? drive_val : 'z;
  assign bus.load_MAR = mar_strobe;
  assign bus.load_MDR = mdr_strobe;
  assign bus.CS       = cs_strobe;
  assign bus.R_NW     = rnw;
  assign bus.ack0     = ack0_o;
  assign bus.ack1     = ack1_o;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state != IDLE);
endmodule
